// File: rtl/fpu_share_arb.sv
// Round-robin arbiter that shares one fixed-latency, non-stallable FP unit between NREQ requesters.
// Optional per-requester sticky error/overflow flags are built when FPU_SHARE_STICKY_EN is defined.
module fpu_share_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          unit_a,
  output logic [31:0]          unit_b,
  input  logic [31:0]          unit_y,
  input  logic                 unit_error,
  input  logic                 unit_overflow,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_y,
  output logic                 rsp_error,
  output logic                 rsp_overflow,
`ifdef FPU_SHARE_STICKY_EN
  input  logic                 sticky_clr,
  output logic [NREQ-1:0]      sticky_err,
  output logic [NREQ-1:0]      sticky_ovf,
`endif
  output logic                 busy
);

  // Handshake: requester i transfers in any cycle where req_valid[i] && req_ready[i].
  // req_ready is one-hot (or zero), depends only on hold, req_valid and the RR pointer,
  // and a requester must hold its operands stable while valid and not yet ready.

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cand;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            inflight;

  logic            tag_v  [0:LAT];
  logic [IDW-1:0]  tag_id [0:LAT];

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (!hold) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = IDW'((int'(ptr) + k) % NREQ);
        if (!grant_any && req_valid[cand]) begin
          grant_any   = 1'b1;
          grant[cand] = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  assign req_ready = grant;

  // One-hot OR mux keeps operand selection off the ready path.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[i*32 +: 32];
        sel_b = sel_b | req_b[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      unit_a <= '0;
      unit_b <= '0;
    end else if (grant_any) begin
      ptr    <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      unit_a <= sel_a;
      unit_b <= sel_b;
    end
  end

  // Ownership tags ride alongside the unit; the last stage lines up with unit_y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int k = 1; k <= LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_y        <= '0;
      rsp_error    <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      rsp_valid <= tag_v[LAT];
      if (tag_v[LAT]) begin
        rsp_id       <= tag_id[LAT];
        rsp_y        <= unit_y;
        rsp_error    <= unit_error;
        rsp_overflow <= unit_overflow;
      end
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int k = 0; k <= LAT; k++) inflight = inflight | tag_v[k];
  end

  assign busy = (|req_valid) | inflight;

`ifdef FPU_SHARE_STICKY_EN
  // Set is evaluated with the response capture so the flag appears alongside rsp_valid; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_err <= '0;
      sticky_ovf <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        sticky_err[i] <= (sticky_err[i] & ~sticky_clr) |
                         (tag_v[LAT] & unit_error & (tag_id[LAT] == IDW'(i)));
        sticky_ovf[i] <= (sticky_ovf[i] & ~sticky_clr) |
                         (tag_v[LAT] & unit_overflow & (tag_id[LAT] == IDW'(i)));
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_share_arb.sv
// Bench for fpu_share_arb: RR grant model, registered unit model and a due-cycle scoreboard.
module tb_fpu_share_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 2;
  localparam int W    = 16 + IDW + 2 + 32;

  logic                clk;
  logic                rst_n;
  logic                hold;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         unit_a;
  logic [31:0]         unit_b;
  logic [31:0]         unit_y;
  logic                unit_error;
  logic                unit_overflow;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_y;
  logic                rsp_error;
  logic                rsp_overflow;
  logic                busy;
`ifdef FPU_SHARE_STICKY_EN
  logic                sticky_clr;
  logic [NREQ-1:0]     sticky_err;
  logic [NREQ-1:0]     sticky_ovf;
  logic [NREQ-1:0]     exp_se;
  logic [NREQ-1:0]     exp_so;
  logic                clr_prev;
`endif

  fpu_share_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (hold),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ready     (req_ready),
    .unit_a        (unit_a),
    .unit_b        (unit_b),
    .unit_y        (unit_y),
    .unit_error    (unit_error),
    .unit_overflow (unit_overflow),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_y         (rsp_y),
    .rsp_error     (rsp_error),
    .rsp_overflow  (rsp_overflow),
`ifdef FPU_SHARE_STICKY_EN
    .sticky_clr    (sticky_clr),
    .sticky_err    (sticky_err),
    .sticky_ovf    (sticky_ovf),
`endif
    .busy          (busy)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- FP unit model (LAT registered stages) ----------------
  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
    return (a ^ {b[15:0], b[31:16]}) + 32'h0001_0003;
  endfunction

  logic [31:0] up_y [LAT];
  logic        up_e [LAT];
  logic        up_o [LAT];
  always @(posedge clk) begin
    up_y[0] <= unit_fn(unit_a, unit_b);
    up_e[0] <= (unit_b == 32'h0);
    up_o[0] <= (unit_a[30:23] == 8'hFF);
    for (int k = 1; k < LAT; k++) begin
      up_y[k] <= up_y[k-1];
      up_e[k] <= up_e[k-1];
      up_o[k] <= up_o[k-1];
    end
  end
  assign unit_y        = up_y[LAT-1];
  assign unit_error    = up_e[LAT-1];
  assign unit_overflow = up_o[LAT-1];

  // ---------------- scoreboard ----------------
  logic [W-1:0]    exp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              mptr = 0;
  int              rsp_cnt = 0;
  int              hs_cnt = 0;
  logic [NREQ-1:0] last_hs = '0;

  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    logic [W-1:0]    e;
    logic [31:0]     ma, mb;
    logic            due_now;
    logic [NREQ-1:0] set_e, set_o;
    int              gid;
    set_e = '0;
    set_o = '0;
    if (!rst_n) begin
      exp_q.delete();
      mptr    = 0;
      last_hs = '0;
`ifdef FPU_SHARE_STICKY_EN
      exp_se   = '0;
      exp_so   = '0;
      clr_prev = 1'b0;
`endif
    end else begin
      eg  = '0;
      gid = -1;
      if (!hold) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (mptr + k) % NREQ;
          if (gid < 0 && req_valid[idx]) gid = idx;
        end
      end
      if (gid >= 0) eg[gid] = 1'b1;
      checks++;
      assert (req_ready === eg) else begin
        errors++;
        $error("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, eg);
      end
      last_hs = req_valid & req_ready;
      if (gid >= 0) begin
        ma = req_a[gid*32 +: 32];
        mb = req_b[gid*32 +: 32];
        exp_q.push_back({16'(cyc + LAT + 2), IDW'(gid), (ma[30:23] == 8'hFF), (mb == 32'h0),
                         unit_fn(ma, mb)});
        mptr = (gid + 1) % NREQ;
        hs_cnt++;
      end

      due_now = (exp_q.size() > 0) && (exp_q[0][W-1 -: 16] == 16'(cyc));
      checks++;
      assert (rsp_valid === due_now) else begin
        errors++;
        $error("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, due_now);
      end
      if (rsp_valid === 1'b1) rsp_cnt++;
      if (due_now) begin
        e = exp_q.pop_front();
        set_e[e[IDW+33:34]] = e[32];
        set_o[e[IDW+33:34]] = e[33];
        if (rsp_valid === 1'b1) begin
          checks++;
          assert ({rsp_id, rsp_overflow, rsp_error, rsp_y} === e[IDW+33:0]) else begin
            errors++;
            $error("FAIL rsp_fields cyc=%0d got id=%0d ovf=%b err=%b y=%h exp id=%0d ovf=%b err=%b y=%h",
                   cyc, rsp_id, rsp_overflow, rsp_error, rsp_y,
                   e[IDW+33:34], e[33], e[32], e[31:0]);
          end
        end
      end

      checks++;
      assert (busy === ((|req_valid) || (exp_q.size() > 0))) else begin
        errors++;
        $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (|req_valid) || (exp_q.size() > 0));
      end
`ifdef FPU_SHARE_STICKY_EN
      exp_se = (exp_se & ~{NREQ{clr_prev}}) | set_e;
      exp_so = (exp_so & ~{NREQ{clr_prev}}) | set_o;
      checks++;
      assert ({sticky_err, sticky_ovf} === {exp_se, exp_so}) else begin
        errors++;
        $error("FAIL sticky cyc=%0d got err=%b ovf=%b exp err=%b ovf=%b",
               cyc, sticky_err, sticky_ovf, exp_se, exp_so);
      end
      clr_prev = sticky_clr;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  int pend[NREQ];
  logic zero_b3 = 1'b0;

  task automatic new_ops(input int i);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    if ($urandom_range(0, 3) == 0) a[30:23] = 8'hFF;
    if (b == 32'h0) b = 32'h1;
    if (zero_b3 && i == 3) b = 32'h0;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic start_req(input int i, input int n);
    pend[i] = n;
    new_ops(i);
    req_valid[i] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (last_hs[i]) begin
        pend[i]--;
        new_ops(i);
      end
      req_valid[i] = (pend[i] > 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    bit active;
    n = 0;
    active = 1'b1;
    while (active && n < 200) begin
      active = (exp_q.size() > 0);
      for (int i = 0; i < NREQ; i++) if (pend[i] > 0) active = 1'b1;
      if (active) begin
        tick();
        n++;
      end
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL drain_%s got=%0d cycles exp=<200", tag, n);
    end
    repeat (2) tick();
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  int rbase;
  int hbase;
  initial begin
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
`ifdef FPU_SHARE_STICKY_EN
    sticky_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check_vec("reset_unit_a", unit_a, 32'h0);
    check_vec("reset_unit_b", unit_b, 32'h0);
    check_vec("reset_rsp_y", rsp_y, 32'h0);
    check_vec("reset_flags", {28'h0, rsp_id, rsp_error, rsp_overflow}, 32'h0);
    check_vec("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // single op from req0
    tick();
    rbase = rsp_cnt;
    start_req(0, 1);
    req_a[31:0] = 32'h3F80_0000;
    req_b[31:0] = 32'h4000_0000;
    tick();
    check_vec("first_unit_a", unit_a, 32'h3F80_0000);
    check_vec("first_unit_b", unit_b, 32'h4000_0000);
    wait_drain("first");
    check_int("first_rsp_count", rsp_cnt - rbase, 1);
    check_vec("first_rsp_y", rsp_y, unit_fn(32'h3F80_0000, 32'h4000_0000));
    check_int("first_rsp_id", int'(rsp_id), 0);

    // all four requesters contending from ptr 0
    do_reset();
    rbase = rsp_cnt;
    hbase = hs_cnt;
    for (int i = 0; i < NREQ; i++) start_req(i, 2);
    repeat (8) tick();
    check_int("rr_grants_in_8", hs_cnt - hbase, 8);
    wait_drain("rr");
    check_int("rr_rsp_count", rsp_cnt - rbase, 8);

    // lone requester, back-to-back
    rbase = rsp_cnt;
    hbase = hs_cnt;
    start_req(2, 5);
    repeat (5) tick();
    check_int("b2b_grants", hs_cnt - hbase, 5);
    wait_drain("b2b");
    check_int("b2b_rsp_count", rsp_cnt - rbase, 5);
    check_int("b2b_last_id", int'(rsp_id), 2);

    // hold after two grants while req1 is still pending
    rbase = rsp_cnt;
    hbase = hs_cnt;
    start_req(0, 1);
    start_req(1, 2);
    tick();
    tick();
    hold = 1'b1;
    repeat (6) tick();
    check_int("hold_grants", hs_cnt - hbase, 2);
    check_int("hold_rsp_count", rsp_cnt - rbase, 2);
    check_vec("hold_busy", 32'(busy), 32'h1);
    check_vec("hold_ready", 32'(req_ready), 32'h0);
    hold = 1'b0;
    wait_drain("hold");
    check_int("hold_rsp_total", rsp_cnt - rbase, 3);
    check_vec("hold_busy_idle", 32'(busy), 32'h0);

    // reset with ops in flight
    start_req(0, 1);
    start_req(1, 1);
    start_req(2, 1);
    repeat (4) tick();
    check_vec("pre_reset_rsp", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_vec("reset_rsp_drop", 32'(rsp_valid), 32'h0);
    check_vec("reset_unit_a_drop", unit_a, 32'h0);
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rbase = rsp_cnt;
    repeat (10) tick();
    check_int("post_reset_no_rsp", rsp_cnt - rbase, 0);
    start_req(3, 1);
    start_req(1, 1);
    #1;
    check_vec("post_reset_ptr0", 32'(req_ready), 32'h2);
    wait_drain("post_reset");

    // error flag only on the req3 result
    zero_b3 = 1'b1;
    rbase = rsp_cnt;
    start_req(3, 1);
    start_req(0, 1);
    start_req(2, 1);
    wait_drain("err");
    zero_b3 = 1'b0;
    check_int("err_rsp_count", rsp_cnt - rbase, 3);
    check_vec("err_last_id_flag", {29'h0, rsp_id, rsp_error}, {29'h0, 2'd3, 1'b1});
`ifdef FPU_SHARE_STICKY_EN
    check_vec("sticky_err_set", 32'(sticky_err), 32'h8);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check_vec("sticky_err_clr", 32'(sticky_err), 32'h0);
`endif

    // random traffic with sporadic hold
    rbase = rsp_cnt;
    hbase = hs_cnt;
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 2) == 0) start_req(i, $urandom_range(1, 3));
      end
      hold = ($urandom_range(0, 4) == 0);
`ifdef FPU_SHARE_STICKY_EN
      sticky_clr = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    hold = 1'b0;
`ifdef FPU_SHARE_STICKY_EN
    sticky_clr = 1'b0;
`endif
    wait_drain("random");
    check_int("random_rsp_vs_grants", rsp_cnt - rbase, hs_cnt - hbase);
    check_int("final_queue_empty", exp_q.size(), 0);
    check_vec("final_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_share_arb.md
Name: fpu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one fixed-latency, non-stallable floating-point unit (the registered FDIV/FMUL core wrapper) between NREQ requesters.
- Accepts operand pairs over valid/ready, issues at most one operation per cycle, and tracks ownership with a tag pipeline.
- Returns each result, with its error/overflow flags and requester id, on a shared response bus.
- Sits between client engines and the FP core in the FPU subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 2, unit latency in cycles: from unit_a/unit_b presented to unit_y/unit_error/unit_overflow valid.
- IDW, $clog2(NREQ), width of response id.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- hold  input  1  when high, blocks new grants; in-flight ops still complete.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  input  NREQ*32  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot grant; transfer when req_valid[i]&req_ready[i].
- unit_a  output  32  registered operand A to the FP unit.
- unit_b  output  32  registered operand B to the FP unit.
- unit_y  input  32  FP unit result.
- unit_error  input  1  FP unit error flag.
- unit_overflow  input  1  FP unit overflow flag.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_id  output  IDW  owning requester.
- rsp_y  output  32  result.
- rsp_error  output  1  error flag of this result.
- rsp_overflow  output  1  overflow flag of this result.
- busy  output  1  any req_valid or any in-flight tag.

Behaviour:
- Reset (async, rst_n low): all outputs 0, RR pointer 0, all tag stages invalid, unit_a/unit_b 0. No state survives reset; in-flight ops are dropped and their late unit outputs are ignored.
- Grant selection (combinational):
  - If hold=0, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - req_ready is all-zero when hold=1 or when no requester is valid.
  - req_ready never depends on the granted requester's own operands.
- On a handshake in cycle T:
  - unit_a/unit_b load the granted operands at the end of T.
  - Tag {valid=1, id=i} enters stage 0.
  - ptr becomes (i+1) mod NREQ.
- No handshake: unit_a/unit_b hold their value; stage 0 loads valid=0; ptr unchanged.
- Tag pipeline is LAT+1 stages deep and shifts every cycle; there is no stall.
- When the last stage is valid, the end-of-cycle registers capture:
  - rsp_valid=1 and rsp_id=tag id;
  - rsp_y=unit_y, rsp_error=unit_error, rsp_overflow=unit_overflow.
  - Otherwise rsp_valid=0 and the other rsp_* outputs hold their value.
- Latency: handshake in cycle T gives rsp_valid in cycle T+LAT+2 (T+4 at default). Throughput is 1 op/cycle; results return in issue order.
- Requester obligation: keep req_a/req_b stable while valid and not ready. The arbiter tolerates valid being dropped without a grant.
- hold asserted mid-stream: no new grants from that cycle. Tags already issued complete normally; busy stays high until the last rsp_valid or while any req_valid is high.
- Single requester: served every cycle (back-to-back grants) while its valid is high.
- Pointer wrap: a grant to NREQ-1 sets ptr to 0.

Optional Feature:
- Macro: FPU_SHARE_STICKY_EN.
- Defined:
  - Add input sticky_clr (1) and outputs sticky_err (NREQ) and sticky_ovf (NREQ).
  - Bit i sets when a response for id i has rsp_error / rsp_overflow set, in the same cycle rsp_valid is driven.
  - Bit i clears on sticky_clr; if set and clear coincide, set wins.
  - Reset value 0.
- Not defined: these ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then req0 a=0x3F800000 b=0x40000000 in cycle T -> unit_a=0x3F800000 in T+1; rsp_valid in T+4 with rsp_id=0 and rsp_y equal to the bench unit model output for that pair.
- All 4 requesters valid continuously for 8 cycles, ptr=0 -> grants 0,1,2,3,0,1,2,3, one per cycle; rsp_id sequence identical; 8 rsp_valid pulses.
- req2 only, valid for 5 cycles -> 5 back-to-back grants; rsp_valid high 5 consecutive cycles, all with rsp_id=2.
- hold=1 in the cycle after 2 grants with req1 still valid -> req_ready=0; both results still return; busy stays 1 until hold drops and req1 is served.
- rst_n pulsed low with 3 ops in flight -> rsp_valid=0 immediately; no responses after release; ptr=0.
- Unit model forces error=1 for the op from req3 -> rsp_error=1 only on the id 3 response; with FPU_SHARE_STICKY_EN, sticky_err=4'b1000 until sticky_clr.
